// File: rtl/dqn_step_scheduler.sv
// Step sequencer for a DQN agent: predict -> select -> act -> (store -> train) per environment step.
// Optional watchdog on PREDICT/SELECT/TRAIN enabled by defining DQN_STEP_TIMEOUT_EN.
module dqn_step_scheduler #(
   parameter int ACTION_WIDTH   = 2,
   parameter int TRAIN_PERIOD   = 4,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_train_mode,
   input  logic                    i_state_valid,
   output logic                    o_predict_valid,
   input  logic                    i_predict_done,
   input  logic [ACTION_WIDTH-1:0] i_action_predict,
   output logic                    o_greedy_valid,
   output logic [ACTION_WIDTH-1:0] o_action_predict,
   input  logic                    i_action_valid,
   input  logic [ACTION_WIDTH-1:0] i_action,
   output logic                    o_env_action_valid,
   output logic [ACTION_WIDTH-1:0] o_env_action,
   input  logic                    i_env_done,
   input  logic                    i_terminal,
   output logic                    o_replay_wr,
   output logic                    o_train_start,
   input  logic                    i_train_done,
   output logic                    o_busy,
   output logic [CNT_WIDTH-1:0]    o_step_count,
   output logic                    o_timeout
);

   // Handshakes are single-cycle qualifiers: an input counts only in the cycle the FSM is in
   // its matching state; it is never stored, and each resulting output pulse appears one cycle later.
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_STATE = 3'd1,
      S_PREDICT    = 3'd2,
      S_SELECT     = 3'd3,
      S_ACT        = 3'd4,
      S_STORE      = 3'd5,
      S_TRAIN      = 3'd6
   } state_t;

   state_t                  r_state;
   state_t                  w_next_state;

   logic [7:0]              r_period_cnt;
   logic                    r_terminal;
   logic                    r_predict_valid;
   logic                    r_greedy_valid;
   logic                    r_env_action_valid;
   logic                    r_replay_wr;
   logic                    r_train_start;
   logic                    r_busy;
   logic [ACTION_WIDTH-1:0] r_action_predict;
   logic [ACTION_WIDTH-1:0] r_env_action;
   logic [CNT_WIDTH-1:0]    r_step_count;

   logic                    w_start;
   logic                    w_predict_valid;
   logic                    w_greedy_valid;
   logic                    w_env_action_valid;
   logic                    w_step_done;
   logic                    w_replay_wr;
   logic                    w_train_start;
   logic                    w_period_hit;
   logic                    w_timeout_hit;

   assign w_period_hit = (r_period_cnt == 8'(TRAIN_PERIOD));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next_state = S_WAIT_STATE;
         end
         S_WAIT_STATE: begin
            if (i_state_valid) w_next_state = S_PREDICT;
         end
         S_PREDICT: begin
            if (i_predict_done)     w_next_state = S_SELECT;
            else if (w_timeout_hit) w_next_state = S_IDLE;
         end
         S_SELECT: begin
            if (i_action_valid)     w_next_state = S_ACT;
            else if (w_timeout_hit) w_next_state = S_IDLE;
         end
         S_ACT: begin
            if (i_env_done) begin
               if (i_train_mode)    w_next_state = S_STORE;
               else if (i_terminal) w_next_state = S_IDLE;
               else                 w_next_state = S_WAIT_STATE;
            end
         end
         S_STORE: begin
            if (w_period_hit)    w_next_state = S_TRAIN;
            else if (r_terminal) w_next_state = S_IDLE;
            else                 w_next_state = S_WAIT_STATE;
         end
         S_TRAIN: begin
            if (i_train_done)       w_next_state = r_terminal ? S_IDLE : S_WAIT_STATE;
            else if (w_timeout_hit) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Output / datapath strobes, registered below
   always_comb begin
      w_start            = 1'b0;
      w_predict_valid    = 1'b0;
      w_greedy_valid     = 1'b0;
      w_env_action_valid = 1'b0;
      w_step_done        = 1'b0;
      w_replay_wr        = 1'b0;
      w_train_start      = 1'b0;
      case (r_state)
         S_IDLE:       w_start            = i_start;
         S_WAIT_STATE: w_predict_valid    = i_state_valid;
         S_PREDICT:    w_greedy_valid     = i_predict_done;
         S_SELECT:     w_env_action_valid = i_action_valid;
         S_ACT: begin
            w_step_done = i_env_done;
            w_replay_wr = i_env_done & i_train_mode;
         end
         S_STORE:      w_train_start      = w_period_hit;
         default:      w_start            = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_predict_valid    <= 1'b0;
         r_greedy_valid     <= 1'b0;
         r_env_action_valid <= 1'b0;
         r_replay_wr        <= 1'b0;
         r_train_start      <= 1'b0;
         r_busy             <= 1'b0;
         r_action_predict   <= '0;
         r_env_action       <= '0;
         r_step_count       <= '0;
         r_period_cnt       <= '0;
         r_terminal         <= 1'b0;
      end else begin
         r_predict_valid    <= w_predict_valid;
         r_greedy_valid     <= w_greedy_valid;
         r_env_action_valid <= w_env_action_valid;
         r_replay_wr        <= w_replay_wr;
         r_train_start      <= w_train_start;
         r_busy             <= (w_next_state != S_IDLE);
         if (w_start) begin
            r_step_count <= '0;
            r_period_cnt <= '0;
         end
         if (w_greedy_valid)     r_action_predict <= i_action_predict;
         if (w_env_action_valid) r_env_action     <= i_action;
         if (w_step_done) begin
            r_step_count <= r_step_count + CNT_WIDTH'(1);
            r_terminal   <= i_terminal;
         end
         // The STORE decision sees the count that already includes this step
         if (w_replay_wr)   r_period_cnt <= r_period_cnt + 8'd1;
         if (w_train_start) r_period_cnt <= '0;
      end
   end

`ifdef DQN_STEP_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout;
   logic            w_watched;
   logic            w_handshake;

   assign w_watched   = (r_state == S_PREDICT) || (r_state == S_SELECT) || (r_state == S_TRAIN);
   assign w_handshake = ((r_state == S_PREDICT) && i_predict_done) ||
                        ((r_state == S_SELECT)  && i_action_valid) ||
                        ((r_state == S_TRAIN)   && i_train_done);
   // Expires at the end of the TIMEOUT_CYCLES-th cycle spent in the same watched state
   assign w_timeout_hit = w_watched && !w_handshake && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wd_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_next_state != r_state) r_wd_cnt <= '0;
         else if (w_watched)          r_wd_cnt <= r_wd_cnt + WD_W'(1);
         if (w_start)            r_timeout <= 1'b0;
         else if (w_timeout_hit) r_timeout <= 1'b1;
      end
   end

   assign o_timeout = r_timeout;
`else
   assign w_timeout_hit = 1'b0;
   assign o_timeout     = 1'b0;
`endif

   assign o_predict_valid    = r_predict_valid;
   assign o_greedy_valid     = r_greedy_valid;
   assign o_action_predict   = r_action_predict;
   assign o_env_action_valid = r_env_action_valid;
   assign o_env_action       = r_env_action;
   assign o_replay_wr        = r_replay_wr;
   assign o_train_start      = r_train_start;
   assign o_busy             = r_busy;
   assign o_step_count       = r_step_count;

endmodule

// File: tb/tb_dqn_step_scheduler.sv
// Randomized bench for dqn_step_scheduler: per-step driver with stray handshakes, pulse monitor,
// env-action scoreboard and a step/period model built from plain counters.
module tb_dqn_step_scheduler;

   localparam int AW = 2;
   localparam int TP = 4;
   localparam int CW = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic          i_train_mode = 1'b0;
   logic          i_state_valid = 1'b0;
   logic          o_predict_valid;
   logic          i_predict_done = 1'b0;
   logic [AW-1:0] i_action_predict = '0;
   logic          o_greedy_valid;
   logic [AW-1:0] o_action_predict;
   logic          i_action_valid = 1'b0;
   logic [AW-1:0] i_action = '0;
   logic          o_env_action_valid;
   logic [AW-1:0] o_env_action;
   logic          i_env_done = 1'b0;
   logic          i_terminal = 1'b0;
   logic          o_replay_wr;
   logic          o_train_start;
   logic          i_train_done = 1'b0;
   logic          o_busy;
   logic [CW-1:0] o_step_count;
   logic          o_timeout;

   dqn_step_scheduler #(
      .ACTION_WIDTH(AW), .TRAIN_PERIOD(TP), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_train_mode(i_train_mode),
      .i_state_valid(i_state_valid), .o_predict_valid(o_predict_valid),
      .i_predict_done(i_predict_done), .i_action_predict(i_action_predict),
      .o_greedy_valid(o_greedy_valid), .o_action_predict(o_action_predict),
      .i_action_valid(i_action_valid), .i_action(i_action),
      .o_env_action_valid(o_env_action_valid), .o_env_action(o_env_action),
      .i_env_done(i_env_done), .i_terminal(i_terminal), .o_replay_wr(o_replay_wr),
      .o_train_start(o_train_start), .i_train_done(i_train_done), .o_busy(o_busy),
      .o_step_count(o_step_count), .o_timeout(o_timeout)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got running expected finished");
      $fatal(1);
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- model state ----------------
   int model_steps  = 0;
   int model_stores = 0;
   int exp_predict = 0, exp_greedy = 0, exp_env = 0, exp_replay = 0, exp_train = 0;
   int mon_predict = 0, mon_greedy = 0, mon_env = 0, mon_replay = 0, mon_train = 0;
   int mon_overlap = 0;
   logic [AW-1:0] exp_q[$];

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         int n;
         n = int'(o_predict_valid) + int'(o_greedy_valid) + int'(o_env_action_valid) +
             int'(o_replay_wr) + int'(o_train_start);
         if (n > 1) mon_overlap++;
         if (o_predict_valid) mon_predict++;
         if (o_greedy_valid)  mon_greedy++;
         if (o_replay_wr)     mon_replay++;
         if (o_train_start)   mon_train++;
         if (o_env_action_valid) begin
            mon_env++;
            check_eq("env_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check_eq("env_action", 32'(o_env_action), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      i_start = 1'b0; i_state_valid = 1'b0; i_predict_done = 1'b0;
      i_action_valid = 1'b0; i_env_done = 1'b0; i_train_done = 1'b0;
   endtask

   // allow bits: 0 start, 1 state_valid, 2 predict_done, 3 action_valid, 4 env_done, 5 train_done
   task automatic noise(input logic [5:0] allow);
      logic [5:0] r;
      r = 6'($urandom) & 6'($urandom) & allow;
      {i_train_done, i_env_done, i_action_valid, i_predict_done, i_state_valid, i_start} = r;
      i_action         = AW'($urandom);
      i_action_predict = AW'($urandom);
      i_terminal       = 1'($urandom);
      i_train_mode     = 1'($urandom);
   endtask

   task automatic wait_phase(input logic [5:0] allow);
      int d;
      d = $urandom_range(0, 3);
      repeat (d) begin
         noise(allow);
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic start_episode();
      wait_phase(6'b111110);
      i_start = 1'b1;
      @(negedge clk);
      idle_inputs();
      model_steps  = 0;
      model_stores = 0;
      check_eq("busy_on_start", 32'(o_busy), 1);
      check_eq("count_cleared", 32'(o_step_count), 0);
   endtask

   task automatic do_reset_now();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_eq("reset_busy", 32'(o_busy), 0);
      check_eq("reset_outputs", 32'({o_predict_valid, o_greedy_valid, o_action_predict,
               o_env_action_valid, o_env_action, o_replay_wr, o_train_start, o_step_count,
               o_timeout}), 0);
      model_steps  = 0;
      model_stores = 0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic do_step(input logic term, input logic tm, input logic [AW-1:0] a,
                          input int stall, input logic rst_in_train);
      logic [AW-1:0] ap;
      ap = AW'($urandom);
      // WAIT_STATE
      wait_phase(6'b111101);
      i_state_valid = 1'b1;
      @(negedge clk);
      idle_inputs();
      check_eq("predict_pulse", 32'(o_predict_valid), 1);
      exp_predict++;
      // PREDICT: a selector result arriving now must be dropped
      i_action_valid = 1'b1;
      i_action       = ~a;
      @(negedge clk);
      idle_inputs();
      check_eq("stray_action_ignored", 32'(o_env_action_valid | o_greedy_valid), 0);
      if (stall > 0) begin
         repeat (stall) @(negedge clk);
         check_eq("stall_busy", 32'(o_busy), 1);
         check_eq("stall_no_timeout", 32'(o_timeout), 0);
      end
      wait_phase(6'b111011);
      i_predict_done   = 1'b1;
      i_action_predict = ap;
      @(negedge clk);
      idle_inputs();
      check_eq("greedy_pulse", 32'(o_greedy_valid), 1);
      check_eq("greedy_action", 32'(o_action_predict), 32'(ap));
      exp_greedy++;
      // SELECT
      wait_phase(6'b110111);
      i_action_valid = 1'b1;
      i_action       = a;
      exp_q.push_back(a);
      @(negedge clk);
      idle_inputs();
      check_eq("env_pulse", 32'(o_env_action_valid), 1);
      exp_env++;
      // ACT
      wait_phase(6'b101111);
      i_env_done   = 1'b1;
      i_terminal   = term;
      i_train_mode = tm;
      @(negedge clk);
      idle_inputs();
      i_train_mode = 1'($urandom);
      model_steps++;
      check_eq("step_count", 32'(o_step_count), 32'(model_steps % (1 << CW)));
      if (tm) begin
         check_eq("replay_wr", 32'(o_replay_wr), 1);
         exp_replay++;
         model_stores++;
         @(negedge clk);
         if (model_stores % TP == 0) begin
            check_eq("train_start", 32'(o_train_start), 1);
            exp_train++;
            if (rst_in_train) begin
               do_reset_now();
               return;
            end
            wait_phase(6'b011111);
            i_train_done = 1'b1;
            @(negedge clk);
            idle_inputs();
         end else begin
            check_eq("no_train", 32'(o_train_start), 0);
         end
      end else begin
         check_eq("no_replay", 32'(o_replay_wr), 0);
      end
      check_eq("busy_after_step", 32'(o_busy), 32'(!term));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r0, t0, len;
      idle_inputs();
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(o_busy), 0);
      check_eq("rst_count", 32'(o_step_count), 0);
      check_eq("rst_actions", 32'({o_env_action, o_action_predict}), 0);
      check_eq("rst_timeout", 32'(o_timeout), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // interactive single terminal step with action 2
      r0 = mon_replay;
      start_episode();
      do_step(1'b1, 1'b0, AW'(2), 0, 1'b0);
      check_eq("single_env_action", 32'(o_env_action), 2);
      check_eq("single_step_count", 32'(o_step_count), 1);
      check_eq("single_idle", 32'(o_busy), 0);
      check_eq("single_no_replay", 32'(mon_replay - r0), 0);

      // training episode: 9 steps, trains after 4 and 8
      r0 = mon_replay;
      t0 = mon_train;
      start_episode();
      for (int s = 0; s < 9; s++) do_step(s == 8, 1'b1, AW'($urandom), 0, 1'b0);
      check_eq("train9_replays", 32'(mon_replay - r0), 9);
      check_eq("train9_trains", 32'(mon_train - t0), 2);

      // step counter wrap: 1,2,3,0,1 then terminal
      start_episode();
      for (int s = 0; s < 6; s++) do_step(s == 5, 1'b0, AW'($urandom), 0, 1'b0);

      // random episodes with mixed train mode
      for (int e = 0; e < 6; e++) begin
         len = $urandom_range(1, 6);
         start_episode();
         for (int s = 0; s < len; s++)
            do_step(s == len - 1, 1'($urandom), AW'($urandom), 0, 1'b0);
      end

`ifdef DQN_STEP_TIMEOUT_EN
      start_episode();
      i_state_valid = 1'b1;
      @(negedge clk);
      idle_inputs();
      check_eq("to_predict_pulse", 32'(o_predict_valid), 1);
      exp_predict++;
      repeat (TO - 1) @(negedge clk);
      check_eq("to_not_yet", 32'({o_timeout, o_busy}), 32'b01);
      @(negedge clk);
      check_eq("to_fired", 32'(o_timeout), 1);
      check_eq("to_idle", 32'(o_busy), 0);
      repeat (3) @(negedge clk);
      check_eq("to_sticky", 32'(o_timeout), 1);
      i_start = 1'b1;
      @(negedge clk);
      idle_inputs();
      model_steps  = 0;
      model_stores = 0;
      check_eq("to_cleared", 32'(o_timeout), 0);
      do_step(1'b1, 1'b0, AW'($urandom), 0, 1'b0);
`else
      start_episode();
      do_step(1'b1, 1'b0, AW'($urandom), 3 * TO, 1'b0);
      check_eq("no_timeout_tied", 32'(o_timeout), 0);
`endif

      // asynchronous reset while training
      start_episode();
      for (int s = 0; s < 4; s++) do_step(1'b0, 1'b1, AW'($urandom), 0, s == 3);
      @(negedge clk);
      check_eq("post_reset_idle", 32'(o_busy), 0);

      // recovery episode
      start_episode();
      for (int s = 0; s < 2; s++) do_step(s == 1, 1'b1, AW'($urandom), 0, 1'b0);

      repeat (3) @(negedge clk);
      check_eq("cnt_predict", 32'(mon_predict), 32'(exp_predict));
      check_eq("cnt_greedy", 32'(mon_greedy), 32'(exp_greedy));
      check_eq("cnt_env", 32'(mon_env), 32'(exp_env));
      check_eq("cnt_replay", 32'(mon_replay), 32'(exp_replay));
      check_eq("cnt_train", 32'(mon_train), 32'(exp_train));
      check_eq("pulse_overlap", 32'(mon_overlap), 0);
      check_eq("env_q_drained", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dqn_step_scheduler.md
DQN_STEP_SCHEDULER -- requirements
Module: dqn_step_scheduler

Interface
REQ-001 SHALL have parameter ACTION_WIDTH, default 2, action code width.
REQ-002 SHALL have parameter TRAIN_PERIOD, default 4, completed steps between training triggers (legal range 1..255).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, step counter width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit in cycles.
REQ-005 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_start  in  1  episode start pulse.
REQ-008 SHALL have port i_train_mode  in  1  1 = store transitions and train; 0 = interactive.
REQ-009 SHALL have port i_state_valid  in  1  environment state ready.
REQ-010 SHALL have port o_predict_valid  out  1  one-cycle pulse that starts the Q-network forward pass.
REQ-011 SHALL have port i_predict_done  in  1  forward pass complete; qualifies i_action_predict.
REQ-012 SHALL have port i_action_predict  in  ACTION_WIDTH  greedy action from the network.
REQ-013 SHALL have port o_greedy_valid  out  1  one-cycle pulse to the epsilon-greedy selector.
REQ-014 SHALL have port o_action_predict  out  ACTION_WIDTH  latched greedy action forwarded to the selector.
REQ-015 SHALL have port i_action_valid  in  1  selector result valid; qualifies i_action.
REQ-016 SHALL have port i_action  in  ACTION_WIDTH  selected action.
REQ-017 SHALL have port o_env_action_valid  out  1  one-cycle pulse that issues the action to the environment.
REQ-018 SHALL have port o_env_action  out  ACTION_WIDTH  action held until the next issue.
REQ-019 SHALL have port i_env_done  in  1  reward and next state ready.
REQ-020 SHALL have port i_terminal  in  1  episode end; sampled with i_env_done.
REQ-021 SHALL have port o_replay_wr  out  1  one-cycle replay-memory write pulse.
REQ-022 SHALL have port o_train_start  out  1  one-cycle training pulse.
REQ-023 SHALL have port i_train_done  in  1  training pass complete.
REQ-024 SHALL have port o_busy  out  1  high whenever the FSM is not in IDLE.
REQ-025 SHALL have port o_step_count  out  CNT_WIDTH  completed steps in the current episode.
REQ-026 SHALL have port o_timeout  out  1  sticky watchdog flag.

Function
REQ-027 SHALL implement the FSM states IDLE, WAIT_STATE, PREDICT, SELECT, ACT, STORE, TRAIN.
REQ-028 SHALL, in IDLE on i_start, clear o_step_count, the period counter and o_timeout, then enter WAIT_STATE; i_start in any other state is ignored.
REQ-029 SHALL, in WAIT_STATE on i_state_valid, pulse o_predict_valid in the next cycle and enter PREDICT.
REQ-030 SHALL, in PREDICT on i_predict_done, latch i_action_predict into o_action_predict, pulse o_greedy_valid in the next cycle and enter SELECT.
REQ-031 SHALL, in SELECT on i_action_valid, latch i_action into o_env_action, pulse o_env_action_valid in the next cycle and enter ACT.
REQ-032 SHALL, in ACT on i_env_done, latch i_terminal and increment o_step_count, which wraps from 2^CNT_WIDTH-1 to 0.
REQ-033 SHALL, from ACT, enter STORE when i_train_mode=1; otherwise go to IDLE if terminal, else to WAIT_STATE.
REQ-034 SHALL, in STORE, pulse o_replay_wr for exactly one cycle and increment the period counter.
REQ-035 SHALL, from STORE, pulse o_train_start and enter TRAIN when the period counter reaches TRAIN_PERIOD, resetting that counter to 0; otherwise go to IDLE if terminal, else to WAIT_STATE.
REQ-036 SHALL, in TRAIN on i_train_done, go to IDLE if terminal, else to WAIT_STATE.
REQ-037 SHALL register all outputs; handshake inputs arriving in any non-matching state are ignored and not queued.
REQ-038 SHALL sample i_train_mode only in ACT; a change at any other time takes effect from the next step.
REQ-039 SHALL have a latency of 1 cycle from each qualifying input to the corresponding output pulse.
REQ-040 SHALL never assert two of the pulse outputs in the same cycle.

Reset
REQ-041 SHALL, on rst_n low, immediately force IDLE and zero all outputs, counters and latched actions, including during any mid-step state.
REQ-042 SHALL ignore every input until the first rising edge after rst_n is released.

Configuration
REQ-043 SHALL, with DQN_STEP_TIMEOUT_EN defined, count cycles spent in each of PREDICT, SELECT and TRAIN, clearing the count on every state change.
REQ-044 SHALL, with DQN_STEP_TIMEOUT_EN defined, set o_timeout and return to IDLE without further pulses when the count reaches TIMEOUT_CYCLES; o_timeout stays high until i_start or reset.
REQ-045 SHALL, without DQN_STEP_TIMEOUT_EN, wait indefinitely in every state and tie o_timeout to 0.

Verification
REQ-046 SHALL cover: i_train_mode=0, one step with i_action=2, i_terminal=1 -> one o_env_action_valid pulse with o_env_action=2, no o_replay_wr, o_step_count=1, back to IDLE.
REQ-047 SHALL cover: i_train_mode=1, TRAIN_PERIOD=4, 9 steps, terminal on step 9 -> 9 o_replay_wr pulses and o_train_start after steps 4 and 8 only.
REQ-048 SHALL cover: i_action_valid asserted while in PREDICT -> ignored; state remains PREDICT.
REQ-049 SHALL cover: rst_n driven low while in TRAIN -> all outputs 0 with no clock edge required; o_busy=0.
REQ-050 SHALL cover: with DQN_STEP_TIMEOUT_EN and TIMEOUT_CYCLES=16, i_predict_done withheld -> o_timeout=1 after 16 cycles in PREDICT, FSM in IDLE; a following i_start clears o_timeout.
REQ-051 SHALL cover: CNT_WIDTH=2, 5 non-terminal steps -> o_step_count sequence 1,2,3,0,1.
